// File: rtl/rib_uart.sv
// UART slave on the RIB bus: 8N1 transmitter/receiver with a small register file.
// Read data is combinational from addr_i; the interrupt is a registered rx_valid & rx_ie.
module rib_uart #(
  parameter int unsigned DEFAULT_BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        irq_o
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_BAUD   = 8'h08;
  localparam logic [7:0] OFF_TXDATA = 8'h0C;
  localparam logic [7:0] OFF_RXDATA = 8'h10;
  localparam logic [15:0] MIN_DIV   = 16'd16;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_over_q, rx_over_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  rxdata_q, rxdata_d;
  logic        irq_q, irq_d;

  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic        tx_q, tx_d;

  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [15:0] rx_div_q, rx_div_d;

  logic [7:0]  off;
  logic        wr_ctrl, wr_status, wr_baud, wr_txdata;
  logic        tx_busy, tx_last, tx_accept;
  logic        rx_en, rx_fall, rx_last, rx_half;
  logic        set_valid, set_over, set_ferr;
  logic [2:0]  w1c;
  logic        unused_ok;

  assign off       = addr_i[7:0];
  assign unused_ok = ^{addr_i[31:8], data_i[31:16]};
  assign wr_ctrl   = we_i && (off == OFF_CTRL);
  assign wr_status = we_i && (off == OFF_STATUS);
  assign wr_baud   = we_i && (off == OFF_BAUD);
  assign wr_txdata = we_i && (off == OFF_TXDATA);
  assign rx_en     = ctrl_q[1];

  assign tx_busy   = (tx_state_q != S_IDLE);
  assign tx_last   = (tx_cnt_q == tx_div_q - 16'd1);
  // The final STOP cycle also accepts a write so frames can run back to back.
  assign tx_accept = wr_txdata && ctrl_q[0] &&
                     (!tx_busy || (tx_state_q == S_STOP && tx_last));

  assign rx_fall   = rx_s3_q & ~rx_s2_q;
  assign rx_last   = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half   = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

  always_comb begin
    ctrl_d = wr_ctrl ? data_i[2:0] : ctrl_q;
    baud_d = baud_q;
    if (wr_baud) baud_d = (data_i[15:0] < MIN_DIV) ? MIN_DIV : data_i[15:0];
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_div_d   = tx_div_q;
    tx_d       = tx_q;
    case (tx_state_q)
      S_START: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_last) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = tx_byte_q[0];
        end
      end
      S_DATA: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_last) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_d     = tx_byte_q[tx_idx_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_last) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: tx_d = 1'b1;
    endcase
    if (tx_accept) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_idx_d   = '0;
      tx_byte_d  = data_i[7:0];
      tx_div_d   = baud_q;
      tx_d       = 1'b0;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_div_d   = rx_div_q;
    rxdata_d   = rxdata_q;
    set_valid  = 1'b0;
    set_over   = 1'b0;
    set_ferr   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_en && rx_fall) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
          rx_div_d   = baud_q;
        end
      end
      S_START: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_half) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end
      end
      default: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s2_q) begin
            rxdata_d  = rx_shift_q;
            set_valid = 1'b1;
            set_over  = rx_valid_q;
          end else begin
            set_ferr = 1'b1;
          end
        end
      end
    endcase
    if (!rx_en && rx_state_q != S_IDLE) begin
      rx_state_d = S_IDLE;
      rx_cnt_d   = '0;
      rxdata_d   = rxdata_q;
      set_valid  = 1'b0;
      set_over   = 1'b0;
      set_ferr   = 1'b0;
    end
  end

  // Hardware set beats a same-edge W1C on every sticky bit.
  always_comb begin
    w1c         = wr_status ? data_i[3:1] : 3'b000;
    rx_valid_d  = (rx_valid_q  & ~w1c[0]) | set_valid;
    rx_over_d   = (rx_over_q   & ~w1c[1]) | set_over;
    frame_err_d = (frame_err_q & ~w1c[2]) | set_ferr;
    irq_d       = rx_valid_q & ctrl_q[2];
  end

  always_comb begin
    case (off)
      OFF_CTRL:   data_o = {29'd0, ctrl_q};
      OFF_STATUS: data_o = {28'd0, frame_err_q, rx_over_q, rx_valid_q, tx_busy};
      OFF_BAUD:   data_o = {16'd0, baud_q};
      OFF_RXDATA: data_o = {24'd0, rxdata_q};
      default:    data_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      ctrl_q      <= '0;
      baud_q      <= 16'(DEFAULT_BAUD_DIV);
      rx_valid_q  <= 1'b0;
      rx_over_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rxdata_q    <= '0;
      irq_q       <= 1'b0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_byte_q   <= '0;
      tx_div_q    <= '0;
      tx_q        <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_div_q    <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      baud_q      <= baud_d;
      rx_valid_q  <= rx_valid_d;
      rx_over_q   <= rx_over_d;
      frame_err_q <= frame_err_d;
      rxdata_q    <= rxdata_d;
      irq_q       <= irq_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_div_q    <= tx_div_d;
      tx_q        <= tx_d;
      rx_s1_q     <= rx_i;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_div_q    <= rx_div_d;
    end
  end

  assign tx_o  = tx_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_rib_uart.sv
// Directed + randomized bench for rib_uart; expected line levels and status bits
// come from a frame-level model (bit index = cycle / div, sticky-flag rules).
module tb_rib_uart;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] data_o;
  logic        tx_o;
  logic        rx_i = 1'b1;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  logic       m_valid = 0, m_over = 0, m_ferr = 0, m_ie = 0;
  logic [7:0] m_rx = '0;

  rib_uart #(.DEFAULT_BAUD_DIV(434)) dut (
    .clk(clk), .rstn(rstn), .addr_i(addr_i), .data_i(data_i), .we_i(we_i),
    .data_o(data_o), .tx_o(tx_o), .rx_i(rx_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr_i = {24'd0, a}; data_i = d; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; addr_i = '0; data_i = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    addr_i = {24'd0, a};
    #1 v = data_o;
    addr_i = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  function automatic logic tx_exp(input logic [7:0] b, input int div, input int k);
    int bi;
    if (k >= 10 * div) return 1'b1;
    bi = k / div;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi - 1];
  endfunction

  // Watches one full frame cycle by cycle; optionally injects a write while busy.
  task automatic tx_frame(input string tag, input logic [7:0] b, input int div, input int poke_k);
    for (int k = 0; k <= 10 * div + 1; k++) begin
      chk({tag, "_line"}, {31'd0, tx_o}, {31'd0, tx_exp(b, div, k)});
      if (addr_i[7:0] == 8'h04)
        chk({tag, "_busy"}, {31'd0, data_o[0]}, {31'd0, (k < 10 * div)});
      if (k == poke_k) begin
        addr_i = 32'h0C; data_i = 32'h5A; we_i = 1'b1;
      end else begin
        addr_i = 32'h04; data_i = '0; we_i = 1'b0;
      end
      @(negedge clk);
    end
    addr_i = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int div);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = fr[i];
      repeat (div) @(negedge clk);
    end
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic m_frame(input logic [7:0] b, input logic stopb);
    if (stopb) begin
      if (m_valid) m_over = 1'b1;
      m_valid = 1'b1;
      m_rx = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic clr(input logic [3:0] mask);
    wr(8'h04, {28'd0, mask});
    if (mask[1]) m_valid = 1'b0;
    if (mask[2]) m_over  = 1'b0;
    if (mask[3]) m_ferr  = 1'b0;
  endtask

  task automatic rx_chk(input string tag);
    @(negedge clk);
    rd_chk({tag, "_status"}, 8'h04, {28'd0, m_ferr, m_over, m_valid, 1'b0});
    rd_chk({tag, "_rxdata"}, 8'h10, {24'd0, m_rx});
    chk({tag, "_irq"}, {31'd0, irq_o}, {31'd0, m_valid & m_ie});
  endtask

  initial begin
    logic [7:0] b;
    logic       sb;
    int         div;

    repeat (3) @(negedge clk);
    rstn = 1'b0;
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    rd_chk("rst_ctrl", 8'h00, 32'd0);
    rd_chk("rst_status", 8'h04, 32'd0);
    rd_chk("rst_baud", 8'h08, 32'd434);
    rd_chk("rst_rxdata", 8'h10, 32'd0);

    wr(8'h08, 32'd5);
    rd_chk("baud_min", 8'h08, 32'd16);
    wr(8'h08, 32'hFFFF_0123);
    rd_chk("baud_wide", 8'h08, 32'h0123);
    rd_chk("txdata_rd0", 8'h0C, 32'd0);
    wr(8'h20, 32'h7);
    rd_chk("bad_off", 8'h20, 32'd0);
    rd_chk("ctrl_untouched", 8'h00, 32'd0);

    // TX disabled: write ignored
    wr(8'h08, 32'd16);
    wr(8'h0C, 32'hFF);
    rd_chk("tx_dis_busy", 8'h04, 32'd0);
    chk("tx_dis_line", {31'd0, tx_o}, 32'd1);

    wr(8'h00, 32'd1);
    rd_chk("ctrl_rd", 8'h00, 32'd1);
    wr(8'h0C, 32'hA5);
    tx_frame("txA5", 8'hA5, 16, 50);

    div = $urandom_range(16, 30);
    b = 8'($urandom);
    wr(8'h08, div);
    wr(8'h0C, {24'd0, b});
    tx_frame("txrnd", b, div, -1);

    wr(8'h08, 32'd16);
    wr(8'h00, 32'h7);
    m_ie = 1'b1;
    send_rx(8'h3C, 1'b1, 16); m_frame(8'h3C, 1'b1);
    rx_chk("rx3C");
    wr(8'h04, 32'h2);
    chk("w1c_irq_lag", {31'd0, irq_o}, 32'd1);
    m_valid = 1'b0;
    @(negedge clk);
    chk("w1c_irq_clr", {31'd0, irq_o}, 32'd0);
    rd_chk("w1c_status", 8'h04, 32'd0);

    send_rx(8'h11, 1'b1, 16); m_frame(8'h11, 1'b1);
    send_rx(8'h22, 1'b1, 16); m_frame(8'h22, 1'b1);
    rx_chk("overrun");
    clr(4'hE);

    b = 8'($urandom);
    send_rx(b, 1'b0, 16); m_frame(b, 1'b0);
    rx_chk("ferr");
    clr(4'hE);

    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    rx_chk("glitch");

    for (int i = 0; i < 4; i++) begin
      div = $urandom_range(16, 24);
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      wr(8'h08, div);
      if ($urandom_range(0, 1) == 1) clr(4'($urandom_range(0, 7) << 1));
      send_rx(b, sb, div); m_frame(b, sb);
      rx_chk("rxrnd");
    end

    wr(8'h00, 32'h1);
    m_ie = 1'b0;
    send_rx(8'h99, 1'b1, 24);
    rx_chk("rx_dis");

    wr(8'h08, 32'd16);
    b = 8'($urandom) & 8'hEF;
    wr(8'h0C, {24'd0, b});
    repeat (88) @(negedge clk);
    chk("mid_bit4", {31'd0, tx_o}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", {31'd0, tx_o}, 32'd1);
    rstn = 1'b0;
    m_valid = 0; m_over = 0; m_ferr = 0; m_rx = '0;
    rd_chk("rst_mid_status", 8'h04, 32'd0);
    rd_chk("rst_mid_baud", 8'h08, 32'd434);
    rd_chk("rst_mid_ctrl", 8'h00, 32'd0);
    chk("rst_mid_irq", {31'd0, irq_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
